tdc_readout_scheduler: RTL and testbench
========================================

// Module: tdc_readout_scheduler
// PURPOSE
//  Round-robin arbiter/sequencer for NUM_CH TDC channels sharing one hit-readout path. Each
//  channel's TDC_Controller/encoder presents a hit (TOA/TOT/Cal code). The scheduler grants one
//  channel per clk40 cycle into a hit FIFO and acks it.
//  It also runs periodic calibration windows: it drives test_mode, then issues an auto_reset pulse to
//  all TDC controllers.
// PARAMETERS
//  NUM_CH      4     number of TDC channels (2..8)
//  TOA_W       10    TOA code width
//  TOT_W       9     TOT code width
//  CAL_W       10    Cal code width
//  FIFO_DEPTH  8     hit FIFO depth; power of 2
//  CAL_PERIOD  1024  clk40 cycles between calibration windows (>= CAL_LEN+2)
//  CAL_LEN     4     cycles test_mode stays high per window
// PORTS
//  clk40       in   1                       40 MHz clock; all logic on rising edge
//  reset       in   1                       synchronous, active-high reset
//  enable      in   1                       scheduler enable
//  ch_valid    in   NUM_CH                  per-channel hit pending; held until ch_ack
//  ch_toa      in   NUM_CH*TOA_W            packed TOA codes; ch i at [i*TOA_W +: TOA_W]
//  ch_tot      in   NUM_CH*TOT_W            packed TOT codes
//  ch_cal      in   NUM_CH*CAL_W            packed Cal codes
//  ch_ack      out  NUM_CH                  one-hot, 1-cycle hit-accepted pulse
//  test_mode   out  1                       to all TDC controllers' testMode
//  auto_reset  out  1                       1-cycle pulse to TDC controllers' autoReset
//  out_valid   out  1                       FIFO head valid
//  out_ready   in   1                       downstream accept
//  out_data    out  1+CH_W+TOA_W+TOT_W+CAL_W  {cal_flag, ch_id, toa, tot, cal}; CH_W=clog2(NUM_CH)
//  fifo_level  out  clog2(FIFO_DEPTH)+1     current FIFO occupancy
//  stall_cnt   out  16                      saturating count of cycles with (ch_valid & ~ch_ack)!=0 and no push
// BEHAVIOUR
//  Reset: all outputs 0.
//  - FIFO is emptied.
//  - RR pointer is 0.
//  - Cal counter is 0.
//  - State is IDLE.
//  Reset asserted mid-operation discards FIFO contents and any pending ack.
//  Arbitration (combinational in cycle n):
//  - eligible = ch_valid & ~ch_ack.
//  - Pick the first eligible channel at or after rr_ptr, wrapping.
//  - A push is allowed when enable=1 AND (fifo_level<FIFO_DEPTH OR (out_valid & out_ready)).
//  - On a push, that channel's fields are written on the edge ending cycle n.
//  - ch_ack[ch] is high in cycle n+1.
//  - rr_ptr becomes (ch+1) mod NUM_CH.
//  - The channel may drop ch_valid in cycle n+2.
//  Latency: push with empty FIFO -> out_valid in cycle n+1. Pop occurs when out_valid & out_ready.
//  FIFO full without a simultaneous pop: no grant; pending channels wait and stall_cnt increments.
//  stall_cnt saturates at 16'hFFFF.
//  cal_flag = test_mode value in the push cycle.
//  FSM states: IDLE, RUN, CAL, CAL_RST.
//  - IDLE: no grants; cal counter held at 0. Goes to RUN when enable=1.
//  - RUN: grants; cal counter increments each cycle. At CAL_PERIOD-1 the counter clears and the FSM goes to CAL.
//  - CAL: test_mode=1 for exactly CAL_LEN cycles, with grants continuing. Then goes to CAL_RST.
//  - CAL_RST: auto_reset=1 for one cycle; no grant in this cycle. Then goes to RUN.
//  - enable=0 in any state: go to IDLE next cycle; test_mode and auto_reset drop the same edge; no new pushes.
//  - Popping continues in IDLE (the FIFO drains).
// STRUCTURE
//  Include tdc_sched_defs.vh (shared with TDC_Controller benches):
//  - FSM state encodings.
//  - Field-offset localparams for the out_data layout.
//  Sub-module tdc_hit_fifo: synchronous FWFT FIFO with level output and same-cycle push/pop when full.
//  Arbiter, FSM and counters live in the top module.
// TESTING
//  1. Single hit: reset, enable=1, ch_valid=4'b0100 for one hit.
//     -> ch_ack=4'b0100 one cycle later; out_data ch_id=2 with codes matching; cal_flag=0.
//  2. Fairness: all 4 ch_valid held with acks honoured.
//     -> grant order 0,1,2,3,0...; no channel acked twice consecutively.
//  3. Full: out_ready=0, 10 hits.
//     -> 8 accepted; fifo_level=8; stall_cnt increments.
//     -> With out_ready=1 and pending hits: pop and push in the same cycle; level stays 8.
//  4. Calibration: CAL_PERIOD=16, CAL_LEN=4.
//     -> test_mode high cycles 16..19 after enable, auto_reset at cycle 20, repeating every 21 cycles.
//     -> Hits granted in the window have cal_flag=1.
//  5. Disable/reset: enable=0 mid-CAL -> test_mode=0 next cycle, FIFO drains.
//     reset with level=5 -> level=0, out_valid=0, rr_ptr=0.

Source files
------------

// File: rtl/tdc_readout_scheduler_pkg.sv
// Shared definitions for the TDC readout scheduler.
//   sched_state_e : sequencer states (IDLE / RUN / CAL / CAL_RST)
//   STALL_W       : width of the saturating stall counter
package tdc_readout_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAL     = 2'd2,
        ST_CAL_RST = 2'd3
    } sched_state_e;

    localparam int unsigned STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/tdc_readout_scheduler_hit_fifo.sv
// tdc_hit_fifo: synchronous first-word-fall-through hit FIFO.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i         : write push_data_i (caller only pushes when not full, or when popping)
//   pop_i          : consume the head word (caller only pops when valid_o)
//   valid_o        : head word present
//   data_o         : head word; forced to zero while empty
//   level_o        : current occupancy, 0..DEPTH
module tdc_hit_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LVL_W-1:0]  level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr: the head is read combinationally this
    // cycle, so overwriting that slot on the same edge as the pop is safe.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (level_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;

endmodule

// File: rtl/tdc_readout_scheduler.sv
// tdc_readout_scheduler: round-robin readout of NUM_CH TDC channels into one hit
// FIFO, plus periodic calibration windows (test_mode, then an auto_reset pulse).
//   clk40_i, reset_i    : 40 MHz clock, synchronous active-high reset
//   enable_i            : scheduler enable; low forces IDLE and blocks grants
//   ch_valid_i          : per-channel hit pending, held until acked
//   ch_toa/tot/cal_i    : packed per-channel codes, channel i at [i*W +: W]
//   ch_ack_o            : one-hot hit-accepted pulse, cycle after the grant
//   test_mode_o         : high during the calibration window
//   auto_reset_o        : one-cycle pulse after each calibration window
//   out_valid_o/_ready_i: FIFO head handshake
//   out_data_o          : {cal_flag, ch_id, toa, tot, cal}
//   fifo_level_o        : FIFO occupancy
//   stall_cnt_o         : saturating count of cycles with a pending hit but no push
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | disabled; no grants, cal counter held at 0, FIFO still drains
// RUN      | grants; cal counter counts up to CAL_PERIOD-1
// CAL      | test_mode high for CAL_LEN cycles, grants continue
// CAL_RST  | auto_reset pulse, no grant this cycle
module tdc_readout_scheduler
    import tdc_readout_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned TOA_W      = 10,
    parameter int unsigned TOT_W      = 9,
    parameter int unsigned CAL_W      = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CAL_PERIOD = 1024,
    parameter int unsigned CAL_LEN    = 4,
    localparam int unsigned CH_W      = $clog2(NUM_CH),
    localparam int unsigned DATA_W    = 1 + CH_W + TOA_W + TOT_W + CAL_W,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk40_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [NUM_CH-1:0]       ch_valid_i,
    input  logic [NUM_CH*TOA_W-1:0] ch_toa_i,
    input  logic [NUM_CH*TOT_W-1:0] ch_tot_i,
    input  logic [NUM_CH*CAL_W-1:0] ch_cal_i,
    output logic [NUM_CH-1:0]       ch_ack_o,
    output logic                    test_mode_o,
    output logic                    auto_reset_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [LVL_W-1:0]        fifo_level_o,
    output logic [STALL_W-1:0]      stall_cnt_o
);

    localparam int unsigned CNT_W = $clog2(CAL_PERIOD);

    sched_state_e       state_q;
    logic [CNT_W-1:0]   cal_cnt_q;
    logic               test_mode_q;
    logic               auto_reset_q;

    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]  ch_ack_q, ch_ack_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_CH-1:0]  eligible;
    logic [CH_W-1:0]    idx;
    logic [CH_W-1:0]    pick;
    logic               found;
    logic               in_run;
    logic               pop;
    logic               push;
    logic [DATA_W-1:0]  push_data;

    always_ff @(posedge clk40_i) begin
        if (reset_i || !enable_i) begin
            state_q      <= ST_IDLE;
            cal_cnt_q    <= '0;
            test_mode_q  <= 1'b0;
            auto_reset_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_RUN;
                    cal_cnt_q <= '0;
                end
                ST_RUN: begin
                    if (cal_cnt_q == CNT_W'(CAL_PERIOD - 1)) begin
                        cal_cnt_q   <= '0;
                        state_q     <= ST_CAL;
                        test_mode_q <= 1'b1;
                    end else begin
                        cal_cnt_q <= cal_cnt_q + 1'b1;
                    end
                end
                ST_CAL: begin
                    // The same counter times the window length.
                    if (cal_cnt_q == CNT_W'(CAL_LEN - 1)) begin
                        cal_cnt_q    <= '0;
                        state_q      <= ST_CAL_RST;
                        test_mode_q  <= 1'b0;
                        auto_reset_q <= 1'b1;
                    end else begin
                        cal_cnt_q <= cal_cnt_q + 1'b1;
                    end
                end
                ST_CAL_RST: begin
                    state_q      <= ST_RUN;
                    cal_cnt_q    <= '0;
                    auto_reset_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        // A channel just acked still shows valid for a cycle; mask it.
        eligible = ch_valid_i & ~ch_ack_q;
        found    = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        pop    = out_valid_o & out_ready_i;
        in_run = (state_q == ST_RUN) || (state_q == ST_CAL);
        push   = enable_i & in_run & found
               & ((fifo_level_o != LVL_W'(FIFO_DEPTH)) | pop);

        push_data = {test_mode_q, pick,
                     ch_toa_i[32'(pick)*TOA_W +: TOA_W],
                     ch_tot_i[32'(pick)*TOT_W +: TOT_W],
                     ch_cal_i[32'(pick)*CAL_W +: CAL_W]};

        rr_ptr_d    = rr_ptr_q;
        ch_ack_d    = '0;
        stall_cnt_d = stall_cnt_q;
        if (push) begin
            rr_ptr_d       = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
            ch_ack_d[pick] = 1'b1;
        end
        if ((|eligible) && !push && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk40_i) begin
        if (reset_i) begin
            rr_ptr_q    <= '0;
            ch_ack_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            ch_ack_q    <= ch_ack_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    tdc_hit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk_i       (clk40_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (out_valid_o),
        .data_o      (out_data_o),
        .level_o     (fifo_level_o)
    );

    assign ch_ack_o     = ch_ack_q;
    assign test_mode_o  = test_mode_q;
    assign auto_reset_o = auto_reset_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_tdc_readout_scheduler.sv
module tb_tdc_readout_scheduler;

    localparam int NCH = 4, TOA_W = 10, TOT_W = 9, CAL_W = 10, DW = 32, LW = 4;

    logic clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    logic reset;
    logic enable, out_ready, enable_c, out_ready_c;
    logic [NCH-1:0] ch_valid, ch_valid_c;
    logic [NCH*TOA_W-1:0] ch_toa;
    logic [NCH*TOT_W-1:0] ch_tot;
    logic [NCH*CAL_W-1:0] ch_cal;

    logic [NCH-1:0] ch_ack, ch_ack_c;
    logic test_mode, auto_reset, out_valid, test_mode_c, auto_reset_c, out_valid_c;
    logic [DW-1:0] out_data, out_data_c;
    logic [LW-1:0] fifo_level, fifo_level_c;
    logic [15:0] stall_cnt, stall_cnt_c;

    int n_checks = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_c_q[$];
    logic [DW-1:0] e_main, e_cal;

    tdc_readout_scheduler dut (
        .clk40_i(clk40), .reset_i(reset), .enable_i(enable), .ch_valid_i(ch_valid),
        .ch_toa_i(ch_toa), .ch_tot_i(ch_tot), .ch_cal_i(ch_cal), .ch_ack_o(ch_ack),
        .test_mode_o(test_mode), .auto_reset_o(auto_reset), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .fifo_level_o(fifo_level),
        .stall_cnt_o(stall_cnt)
    );

    tdc_readout_scheduler #(.CAL_PERIOD(16), .CAL_LEN(4)) dut_c (
        .clk40_i(clk40), .reset_i(reset), .enable_i(enable_c), .ch_valid_i(ch_valid_c),
        .ch_toa_i(ch_toa), .ch_tot_i(ch_tot), .ch_cal_i(ch_cal), .ch_ack_o(ch_ack_c),
        .test_mode_o(test_mode_c), .auto_reset_o(auto_reset_c), .out_valid_o(out_valid_c),
        .out_ready_i(out_ready_c), .out_data_o(out_data_c), .fifo_level_o(fifo_level_c),
        .stall_cnt_o(stall_cnt_c)
    );

    // Scoreboards: every accepted FIFO head word is compared with the oldest expectation.
    always @(negedge clk40) begin
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL out_data_unexpected: got %h want none", out_data);
            else begin
                e_main = exp_q.pop_front();
                if (out_data !== e_main) $display("FAIL out_data: got %h want %h", out_data, e_main);
                else n_pass++;
            end
        end
        if (!reset && out_valid_c && out_ready_c) begin
            n_checks++;
            if (exp_c_q.size() == 0) $display("FAIL cal_out_data_unexpected: got %h want none", out_data_c);
            else begin
                e_cal = exp_c_q.pop_front();
                if (out_data_c !== e_cal) $display("FAIL cal_out_data: got %h want %h", out_data_c, e_cal);
                else n_pass++;
            end
        end
    end

    function automatic logic [DW-1:0] exp_word(input logic flag, input int ch);
        logic [1:0] c;
        c = 2'(ch);
        return {flag, c, ch_toa[ch*TOA_W +: TOA_W], ch_tot[ch*TOT_W +: TOT_W], ch_cal[ch*CAL_W +: CAL_W]};
    endfunction

    task automatic new_codes(input int ch);
        ch_toa[ch*TOA_W +: TOA_W] = 10'($urandom);
        ch_tot[ch*TOT_W +: TOT_W] = 9'($urandom);
        ch_cal[ch*CAL_W +: CAL_W] = 10'($urandom);
    endtask

    task automatic step();
        @(posedge clk40);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; enable_c = 1'b0;
        ch_valid = '0; ch_valid_c = '0;
        out_ready = 1'b0; out_ready_c = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_c_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ch_ack !== 4'b0) $display("FAIL rst_ack: got %b want 0000", ch_ack); else n_pass++;
        n_checks++; if (test_mode !== 1'b0) $display("FAIL rst_test_mode: got %b want 0", test_mode); else n_pass++;
        n_checks++; if (auto_reset !== 1'b0) $display("FAIL rst_auto_reset: got %b want 0", auto_reset); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (fifo_level !== '0) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (stall_cnt !== '0) $display("FAIL rst_stall: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_single_hit();
        do_reset();
        enable = 1'b1;
        step();
        new_codes(2);
        ch_valid = 4'b0100;
        exp_q.push_back(exp_word(1'b0, 2));
        step();
        n_checks++; if (ch_ack !== 4'b0100) $display("FAIL single_ack: got %b want 0100", ch_ack); else n_pass++;
        n_checks++; if (fifo_level !== 4'd1) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else n_pass++;
        ch_valid = '0;
        out_ready = 1'b1;
        step();
        n_checks++; if (ch_ack !== 4'b0) $display("FAIL single_ack_clear: got %b want 0000", ch_ack); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL single_level_pop: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (stall_cnt !== 16'd0) $display("FAIL single_stall: got %0d want 0", stall_cnt); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_fairness();
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        step();
        for (int c = 0; c < NCH; c++) new_codes(c);
        ch_valid = 4'hF;
        exp_q.push_back(exp_word(1'b0, 0));
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (ch_ack !== 4'(1 << (k % 4))) $display("FAIL rr_ack[%0d]: got %b want %b", k, ch_ack, 4'(1 << (k % 4)));
            else n_pass++;
            new_codes(k % 4);
            if (k + 1 < 12) exp_q.push_back(exp_word(1'b0, (k + 1) % 4));
            else ch_valid = '0;
        end
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++; if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_full();
        int presented;
        do_reset();
        enable = 1'b1;
        step();
        for (int c = 0; c < NCH; c++) new_codes(c);
        presented = 4;
        ch_valid = 4'hF;
        exp_q.push_back(exp_word(1'b0, 0));
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (ch_ack !== 4'(1 << (k % 4))) $display("FAIL full_ack[%0d]: got %b want %b", k, ch_ack, 4'(1 << (k % 4)));
            else n_pass++;
            n_checks++;
            if (fifo_level !== 4'(k + 1)) $display("FAIL full_level[%0d]: got %0d want %0d", k, fifo_level, k + 1);
            else n_pass++;
            if (presented < 10) begin
                new_codes(k % 4);
                presented++;
            end else begin
                ch_valid[k % 4] = 1'b0;
            end
            if (k < 7) exp_q.push_back(exp_word(1'b0, (k + 1) % 4));
        end
        for (int j = 1; j <= 5; j++) begin
            step();
            n_checks++; if (ch_ack !== 4'b0) $display("FAIL full_no_grant[%0d]: got %b want 0000", j, ch_ack); else n_pass++;
            n_checks++; if (stall_cnt !== 16'(j)) $display("FAIL full_stall[%0d]: got %0d want %0d", j, stall_cnt, j); else n_pass++;
        end
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL full_level_hold: got %0d want 8", fifo_level); else n_pass++;
        out_ready = 1'b1;
        exp_q.push_back(exp_word(1'b0, 0));
        step();
        n_checks++; if (ch_ack !== 4'b0001) $display("FAIL full_swap_ack0: got %b want 0001", ch_ack); else n_pass++;
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL full_swap_level0: got %0d want 8", fifo_level); else n_pass++;
        ch_valid[0] = 1'b0;
        exp_q.push_back(exp_word(1'b0, 1));
        step();
        n_checks++; if (ch_ack !== 4'b0010) $display("FAIL full_swap_ack1: got %b want 0010", ch_ack); else n_pass++;
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL full_swap_level1: got %0d want 8", fifo_level); else n_pass++;
        ch_valid[1] = 1'b0;
        step();
        n_checks++; if (fifo_level !== 4'd7) $display("FAIL full_pop_level: got %0d want 7", fifo_level); else n_pass++;
        n_checks++; if (stall_cnt !== 16'd5) $display("FAIL full_stall_final: got %0d want 5", stall_cnt); else n_pass++;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++; if (exp_q.size() != 0) $display("FAIL full_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_calibration();
        logic exp_tm, exp_ar;
        logic [3:0] exp_ack;
        do_reset();
        out_ready_c = 1'b1;
        enable_c = 1'b1;
        step();
        for (int t = 0; t < 48; t++) begin
            exp_tm = ((t % 21) >= 16) && ((t % 21) < 20);
            exp_ar = ((t % 21) == 20);
            exp_ack = (t == 6) ? 4'b0100 : (t == 18) ? 4'b0010 : (t == 22) ? 4'b1000 : 4'b0000;
            n_checks++; if (test_mode_c !== exp_tm) $display("FAIL cal_test_mode[t=%0d]: got %b want %b", t, test_mode_c, exp_tm); else n_pass++;
            n_checks++; if (auto_reset_c !== exp_ar) $display("FAIL cal_auto_reset[t=%0d]: got %b want %b", t, auto_reset_c, exp_ar); else n_pass++;
            n_checks++; if (ch_ack_c !== exp_ack) $display("FAIL cal_ack[t=%0d]: got %b want %b", t, ch_ack_c, exp_ack); else n_pass++;
            case (t)
                5:  begin new_codes(2); ch_valid_c[2] = 1'b1; exp_c_q.push_back(exp_word(1'b0, 2)); end
                6:  ch_valid_c[2] = 1'b0;
                17: begin new_codes(1); ch_valid_c[1] = 1'b1; exp_c_q.push_back(exp_word(1'b1, 1)); end
                18: ch_valid_c[1] = 1'b0;
                20: begin new_codes(3); ch_valid_c[3] = 1'b1; exp_c_q.push_back(exp_word(1'b0, 3)); end
                22: ch_valid_c[3] = 1'b0;
                default: ;
            endcase
            step();
        end
        n_checks++; if (exp_c_q.size() != 0) $display("FAIL cal_drain: got %0d left want 0", exp_c_q.size()); else n_pass++;
    endtask

    task automatic test_disable_mid_cal();
        do_reset();
        enable_c = 1'b1;
        step();
        for (int t = 0; t < 17; t++) begin
            if (t == 0) begin
                for (int c = 0; c < 3; c++) new_codes(c);
                ch_valid_c = 4'b0111;
                for (int c = 0; c < 3; c++) exp_c_q.push_back(exp_word(1'b0, c));
            end else if (t <= 3) begin
                ch_valid_c[t - 1] = 1'b0;
            end
            step();
        end
        n_checks++; if (test_mode_c !== 1'b1) $display("FAIL dis_in_cal: got %b want 1", test_mode_c); else n_pass++;
        n_checks++; if (fifo_level_c !== 4'd3) $display("FAIL dis_level_pre: got %0d want 3", fifo_level_c); else n_pass++;
        enable_c = 1'b0;
        new_codes(3);
        ch_valid_c[3] = 1'b1;
        step();
        n_checks++; if (test_mode_c !== 1'b0) $display("FAIL dis_test_mode: got %b want 0", test_mode_c); else n_pass++;
        n_checks++; if (auto_reset_c !== 1'b0) $display("FAIL dis_auto_reset: got %b want 0", auto_reset_c); else n_pass++;
        n_checks++; if (fifo_level_c !== 4'd3) $display("FAIL dis_no_push: got %0d want 3", fifo_level_c); else n_pass++;
        out_ready_c = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            n_checks++; if (ch_ack_c !== 4'b0) $display("FAIL dis_ack[%0d]: got %b want 0000", j, ch_ack_c); else n_pass++;
            n_checks++; if (fifo_level_c !== 4'(3 - j)) $display("FAIL dis_drain_level[%0d]: got %0d want %0d", j, fifo_level_c, 3 - j); else n_pass++;
        end
        n_checks++; if (out_valid_c !== 1'b0) $display("FAIL dis_out_valid: got %b want 0", out_valid_c); else n_pass++;
        n_checks++; if (exp_c_q.size() != 0) $display("FAIL dis_drain: got %0d left want 0", exp_c_q.size()); else n_pass++;
        ch_valid_c = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1;
        step();
        for (int c = 0; c < NCH; c++) new_codes(c);
        ch_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (ch_ack !== 4'(1 << (k % 4))) $display("FAIL rmid_ack[%0d]: got %b want %b", k, ch_ack, 4'(1 << (k % 4)));
            else n_pass++;
            if (k == 0) new_codes(0);
            else ch_valid[k % 4] = 1'b0;
        end
        n_checks++; if (fifo_level !== 4'd5) $display("FAIL rmid_level_pre: got %0d want 5", fifo_level); else n_pass++;
        reset = 1'b1;
        ch_valid = '0;
        step();
        reset = 1'b0;
        n_checks++; if (ch_ack !== 4'b0) $display("FAIL rmid_ack_clear: got %b want 0000", ch_ack); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL rmid_level: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rmid_out_data: got %h want 0", out_data); else n_pass++;
        new_codes(0);
        new_codes(1);
        ch_valid = 4'b0011;
        exp_q.push_back(exp_word(1'b0, 0));
        exp_q.push_back(exp_word(1'b0, 1));
        step();
        step();
        n_checks++; if (ch_ack !== 4'b0001) $display("FAIL rmid_rr_first: got %b want 0001", ch_ack); else n_pass++;
        ch_valid[0] = 1'b0;
        step();
        n_checks++; if (ch_ack !== 4'b0010) $display("FAIL rmid_rr_second: got %b want 0010", ch_ack); else n_pass++;
        ch_valid[1] = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        n_checks++; if (exp_q.size() != 0) $display("FAIL rmid_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0; enable_c = 1'b0;
        out_ready = 1'b0; out_ready_c = 1'b0;
        ch_valid = '0; ch_valid_c = '0;
        ch_toa = '0; ch_tot = '0; ch_cal = '0;
        test_reset();
        test_single_hit();
        test_fairness();
        test_full();
        test_calibration();
        test_disable_mid_cal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
